// File: rtl/memop_responder.sv
// Load/store responder: queues execute-stage memops, issues them one at a time to the
// cache, formats store lanes and load results, and reports faults and register writebacks.
module memop_responder #(
    parameter int unsigned RISCV_ARCH        = 64,
    parameter int unsigned CFG_REG_TAG_WIDTH = 3,
    parameter int unsigned QUEUE_ABITS       = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,

    input  logic                         i_memop_valid,
    output logic                         o_memop_ready,
    input  logic                         i_memop_store,
    input  logic                         i_memop_sign_ext,
    input  logic [1:0]                   i_memop_size,
    input  logic [RISCV_ARCH-1:0]        i_memop_addr,
    input  logic [RISCV_ARCH-1:0]        i_memop_wdata,
    input  logic [5:0]                   i_memop_waddr,
    input  logic [CFG_REG_TAG_WIDTH-1:0] i_memop_wtag,

    output logic                         o_mem_req_valid,
    output logic                         o_mem_req_write,
    output logic [RISCV_ARCH-1:0]        o_mem_req_addr,
    output logic [63:0]                  o_mem_req_wdata,
    output logic [7:0]                   o_mem_req_wstrb,
    output logic [1:0]                   o_mem_req_size,
    input  logic                         i_mem_req_ready,

    input  logic                         i_mem_resp_valid,
    input  logic [63:0]                  i_mem_resp_data,
    input  logic                         i_mem_resp_fault,
    output logic                         o_mem_resp_ready,

    output logic                         o_wb_valid,
    output logic [5:0]                   o_wb_waddr,
    output logic [RISCV_ARCH-1:0]        o_wb_wdata,
    output logic [CFG_REG_TAG_WIDTH-1:0] o_wb_wtag,
    input  logic                         i_wb_ready,

    output logic                         o_fault_load,
    output logic                         o_fault_store,
    output logic                         o_fault_misalign,
    output logic [RISCV_ARCH-1:0]        o_fault_addr,

    output logic                         o_idle
);

    localparam int unsigned DEPTH = 2 ** QUEUE_ABITS;
    localparam int unsigned CW    = QUEUE_ABITS + 1;

    typedef struct packed {
        logic                         store;
        logic                         sign_ext;
        logic [1:0]                   size;
        logic [RISCV_ARCH-1:0]        addr;
        logic [RISCV_ARCH-1:0]        wdata;
        logic [5:0]                   waddr;
        logic [CFG_REG_TAG_WIDTH-1:0] wtag;
    } memop_t;

    typedef enum logic [1:0] {StIdle, StRequest, StWaitResp, StWriteback} state_e;

    memop_t                 queue_mem [DEPTH];
    memop_t                 push_entry;
    logic [QUEUE_ABITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   full, empty, push, pop;

    state_e                 state_q, state_d;
    memop_t                 op_q;
    logic [RISCV_ARCH-1:0]  wb_data_q;
    logic                   load_wb;
    logic                   misaligned;
    logic [63:0]            wdata64, lanes, shifted, ext;
    logic [7:0]             strb_base;

    // ---------------------------------------------------------------- request queue
    always_comb begin
        push_entry          = '0;
        push_entry.store    = i_memop_store;
        push_entry.sign_ext = i_memop_sign_ext;
        push_entry.size     = i_memop_size;
        push_entry.addr     = i_memop_addr;
        push_entry.wdata    = i_memop_wdata;
        push_entry.waddr    = i_memop_waddr;
        push_entry.wtag     = i_memop_wtag;
    end

    assign full          = (count_q == CW'(DEPTH));
    assign empty         = (count_q == '0);
    assign o_memop_ready = !full;
    assign push          = i_memop_valid && !full;
    assign pop           = (state_q == StIdle) && !empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            queue_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + QUEUE_ABITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + QUEUE_ABITS'(1);
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        misaligned = 1'b0;
        strb_base  = 8'h00;
        lanes      = '0;
        wdata64    = 64'(op_q.wdata);
        unique case (op_q.size)
            2'd0: begin misaligned = 1'b0;           strb_base = 8'h01; lanes = {8{wdata64[7:0]}};  end
            2'd1: begin misaligned = op_q.addr[0];   strb_base = 8'h03; lanes = {4{wdata64[15:0]}}; end
            2'd2: begin misaligned = |op_q.addr[1:0]; strb_base = 8'h0F; lanes = {2{wdata64[31:0]}}; end
            2'd3: begin misaligned = |op_q.addr[2:0]; strb_base = 8'hFF; lanes = wdata64;           end
            default: ;
        endcase
    end

    // Load result: move the addressed bytes down to lane 0, then truncate and extend
    always_comb begin
        shifted = i_mem_resp_data >> {op_q.addr[2:0], 3'b000};
        ext     = '0;
        unique case (op_q.size)
            2'd0: ext = {{56{op_q.sign_ext & shifted[7]}},  shifted[7:0]};
            2'd1: ext = {{48{op_q.sign_ext & shifted[15]}}, shifted[15:0]};
            2'd2: ext = {{32{op_q.sign_ext & shifted[31]}}, shifted[31:0]};
            2'd3: ext = shifted;
            default: ;
        endcase
    end

    assign o_mem_req_write = op_q.store;
    assign o_mem_req_addr  = op_q.addr;
    assign o_mem_req_size  = op_q.size;
    assign o_mem_req_wdata = op_q.store ? lanes : 64'h0;
    assign o_mem_req_wstrb = op_q.store ? (strb_base << op_q.addr[2:0]) : 8'h00;
    assign o_wb_waddr      = op_q.waddr;
    assign o_wb_wtag       = op_q.wtag;
    assign o_wb_wdata      = wb_data_q;
    assign o_fault_addr    = op_q.addr;
    assign o_idle          = empty && (state_q == StIdle);

    // ---------------------------------------------------------------- control FSM
    always_comb begin
        state_d          = state_q;
        o_mem_req_valid  = 1'b0;
        o_mem_resp_ready = 1'b0;
        o_wb_valid       = 1'b0;
        o_fault_load     = 1'b0;
        o_fault_store    = 1'b0;
        o_fault_misalign = 1'b0;
        load_wb          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) state_d = StRequest;
            end
            StRequest: begin
                if (misaligned) begin
                    o_fault_misalign = 1'b1;
                    state_d          = StIdle;
                end else begin
                    o_mem_req_valid = 1'b1;
                    if (i_mem_req_ready) state_d = StWaitResp;
                end
            end
            StWaitResp: begin
                o_mem_resp_ready = 1'b1;
                if (i_mem_resp_valid) begin
                    if (i_mem_resp_fault) begin
                        o_fault_load  = !op_q.store;
                        o_fault_store = op_q.store;
                        state_d       = StIdle;
                    end else if (op_q.store || (op_q.waddr == 6'd0)) begin
                        state_d = StIdle;
                    end else begin
                        load_wb = 1'b1;
                        state_d = StWriteback;
                    end
                end
            end
            StWriteback: begin
                o_wb_valid = 1'b1;
                if (i_wb_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop)     op_q      <= queue_mem[rd_ptr_q];
            if (load_wb) wb_data_q <= RISCV_ARCH'(ext);
        end
    end

endmodule

// File: tb/tb_memop_responder.sv
// Self-checking bench for memop_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_memop_responder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_memop_valid, o_memop_ready;
    logic        i_memop_store, i_memop_sign_ext;
    logic [1:0]  i_memop_size;
    logic [63:0] i_memop_addr, i_memop_wdata;
    logic [5:0]  i_memop_waddr;
    logic [2:0]  i_memop_wtag;
    logic        o_mem_req_valid, o_mem_req_write, i_mem_req_ready;
    logic [63:0] o_mem_req_addr, o_mem_req_wdata;
    logic [7:0]  o_mem_req_wstrb;
    logic [1:0]  o_mem_req_size;
    logic        i_mem_resp_valid, i_mem_resp_fault, o_mem_resp_ready;
    logic [63:0] i_mem_resp_data;
    logic        o_wb_valid, i_wb_ready;
    logic [5:0]  o_wb_waddr;
    logic [63:0] o_wb_wdata;
    logic [2:0]  o_wb_wtag;
    logic        o_fault_load, o_fault_store, o_fault_misalign;
    logic [63:0] o_fault_addr;
    logic        o_idle;

    memop_responder #(.RISCV_ARCH(64), .CFG_REG_TAG_WIDTH(3), .QUEUE_ABITS(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_memop_valid(i_memop_valid), .o_memop_ready(o_memop_ready),
        .i_memop_store(i_memop_store), .i_memop_sign_ext(i_memop_sign_ext),
        .i_memop_size(i_memop_size), .i_memop_addr(i_memop_addr),
        .i_memop_wdata(i_memop_wdata), .i_memop_waddr(i_memop_waddr),
        .i_memop_wtag(i_memop_wtag),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_req_write(o_mem_req_write),
        .o_mem_req_addr(o_mem_req_addr), .o_mem_req_wdata(o_mem_req_wdata),
        .o_mem_req_wstrb(o_mem_req_wstrb), .o_mem_req_size(o_mem_req_size),
        .i_mem_req_ready(i_mem_req_ready),
        .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_data(i_mem_resp_data),
        .i_mem_resp_fault(i_mem_resp_fault), .o_mem_resp_ready(o_mem_resp_ready),
        .o_wb_valid(o_wb_valid), .o_wb_waddr(o_wb_waddr), .o_wb_wdata(o_wb_wdata),
        .o_wb_wtag(o_wb_wtag), .i_wb_ready(i_wb_ready),
        .o_fault_load(o_fault_load), .o_fault_store(o_fault_store),
        .o_fault_misalign(o_fault_misalign), .o_fault_addr(o_fault_addr),
        .o_idle(o_idle)
    );

    always #5 i_clk = ~i_clk;

    localparam int DEPTH = 2;

    int errors = 0;
    int checks = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    typedef struct {
        bit        store;
        bit        sign;
        bit [1:0]  size;
        bit [63:0] addr;
        bit [63:0] wdata;
        bit [5:0]  waddr;
        bit [2:0]  wtag;
    } op_t;

    op_t       model[$];      // accepted, not yet completed, oldest first
    bit        issued;        // head op's cache request accepted, response pending
    bit        wbp;           // head op's writeback pending
    bit [63:0] wb_exp;
    bit        stall;

    function automatic bit is_aligned(op_t o);
        int unsigned nb = 1 << o.size;
        return (o.addr & 64'(nb - 1)) == 64'd0;
    endfunction

    function automatic logic [7:0] exp_strb(op_t o);
        logic [7:0] s   = 8'h00;
        int         off = int'(o.addr[2:0]);
        int         nb  = 1 << o.size;
        for (int i = 0; i < 8; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
        return o.store ? s : 8'h00;
    endfunction

    function automatic logic [63:0] exp_lanes(op_t o);
        logic [63:0] d  = 64'h0;
        int          nb = 1 << o.size;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = o.wdata[8*(i % nb) +: 8];
        return d;
    endfunction

    function automatic logic [63:0] load_value(op_t o, logic [63:0] data);
        int          nb   = 1 << o.size;
        logic [63:0] v    = data >> (8 * int'(o.addr[2:0]));
        logic [63:0] mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v = v & mask;
        if (o.sign && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic monitor_cycle();
        op_t h;
        bit  have, resp_hs, done, efl, efs;
        have = model.size() > 0;
        if (have) h = model[0];
        check1("idle", o_idle, model.size() == 0);
        if (model.size() < DEPTH) check1("memop_ready", o_memop_ready, 1'b1);
        if (model.size() > DEPTH) check1("memop_ready_full", o_memop_ready, 1'b0);
        check1("resp_ready", o_mem_resp_ready, have && issued);
        if (stall) check1("req_held", o_mem_req_valid, 1'b1);
        if (o_mem_req_valid) begin
            check1("req_legal", have && !issued && !wbp && is_aligned(h), 1'b1);
            if (have) begin
                check64("req_addr", o_mem_req_addr, h.addr);
                check1("req_write", o_mem_req_write, h.store);
                check64("req_size", 64'(o_mem_req_size), 64'(h.size));
                check64("req_wstrb", 64'(o_mem_req_wstrb), 64'(exp_strb(h)));
                if (h.store) check64("req_wdata", o_mem_req_wdata, exp_lanes(h));
            end
        end
        check1("wb_valid", o_wb_valid, wbp);
        if (o_wb_valid && have) begin
            check64("wb_waddr", 64'(o_wb_waddr), 64'(h.waddr));
            check64("wb_wtag", 64'(o_wb_wtag), 64'(h.wtag));
            check64("wb_wdata", o_wb_wdata, wb_exp);
        end
        resp_hs = o_mem_resp_ready && i_mem_resp_valid;
        efl = have && resp_hs && i_mem_resp_fault && !h.store;
        efs = have && resp_hs && i_mem_resp_fault && h.store;
        check1("fault_load", o_fault_load, efl);
        check1("fault_store", o_fault_store, efs);
        if (efl || efs) check64("fault_addr", o_fault_addr, h.addr);
        if (o_fault_misalign) begin
            check1("misalign_legal", have && !issued && !wbp && !is_aligned(h), 1'b1);
            if (have) check64("misalign_addr", o_fault_addr, h.addr);
        end
        done = 1'b0;
        if (have) begin
            if (o_fault_misalign) done = 1'b1;
            if (o_mem_req_valid && i_mem_req_ready) issued = 1'b1;
            if (resp_hs) begin
                issued = 1'b0;
                if (i_mem_resp_fault || h.store || h.waddr == 6'd0) begin
                    done = 1'b1;
                end else begin
                    wbp    = 1'b1;
                    wb_exp = load_value(h, i_mem_resp_data);
                end
            end
            if (o_wb_valid && i_wb_ready && wbp) begin
                wbp  = 1'b0;
                done = 1'b1;
            end
        end
        stall = o_mem_req_valid && !i_mem_req_ready;
        if (done) void'(model.pop_front());
        if (i_memop_valid && o_memop_ready) begin
            h.store = i_memop_store;  h.sign  = i_memop_sign_ext; h.size = i_memop_size;
            h.addr  = i_memop_addr;   h.wdata = i_memop_wdata;
            h.waddr = i_memop_waddr;  h.wtag  = i_memop_wtag;
            model.push_back(h);
        end
    endtask

    initial begin
        issued = 1'b0; wbp = 1'b0; stall = 1'b0; wb_exp = '0;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst) begin
                check1("rst_idle", o_idle, 1'b1);
                check1("rst_memop_ready", o_memop_ready, 1'b1);
                check1("rst_req_valid", o_mem_req_valid, 1'b0);
                check1("rst_wb_valid", o_wb_valid, 1'b0);
                model.delete();
                issued = 1'b0; wbp = 1'b0; stall = 1'b0;
            end else begin
                monitor_cycle();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic push_op(input bit store, input bit sign, input bit [1:0] size,
                           input bit [63:0] addr, input bit [63:0] wdata,
                           input bit [5:0] waddr, input bit [2:0] wtag);
        bit ok = 1'b0;
        i_memop_valid = 1'b1; i_memop_store = store; i_memop_sign_ext = sign;
        i_memop_size  = size; i_memop_addr  = addr;  i_memop_wdata    = wdata;
        i_memop_waddr = waddr; i_memop_wtag = wtag;
        for (int n = 0; n < 50; n++) begin
            #3;
            if (o_memop_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        i_memop_valid = 1'b0;
        check1("push_accept", ok, 1'b1);
    endtask

    task automatic observe(input bit fault, output bit saw_req, output logic [63:0] req_wdata,
                           output logic [7:0] req_strb, output int wb_cycles,
                           output int mis_cycles, output logic [63:0] mis_addr,
                           output int fs_cycles, output bit finished);
        saw_req = 1'b0; req_wdata = '0; req_strb = '0; wb_cycles = 0;
        mis_cycles = 0; mis_addr = '0; fs_cycles = 0; finished = 1'b0;
        i_mem_req_ready = 1'b1; i_mem_resp_valid = 1'b1; i_mem_resp_fault = fault;
        i_mem_resp_data = 64'h0123_4567_89AB_CDEF; i_wb_ready = 1'b1;
        for (int n = 0; n < 40 && !finished; n++) begin
            #3;
            if (o_mem_req_valid && !saw_req) begin
                saw_req = 1'b1; req_wdata = o_mem_req_wdata; req_strb = o_mem_req_wstrb;
            end
            if (o_wb_valid) wb_cycles++;
            if (o_fault_misalign) begin
                mis_cycles++;
                mis_addr = o_fault_addr;
            end
            if (o_fault_store) fs_cycles++;
            finished = o_idle;
            tick();
        end
        i_mem_resp_valid = 1'b0; i_mem_resp_fault = 1'b0;
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin
        bit          saw_req, fin;
        logic [63:0] rwd, maddr;
        logic [7:0]  rst_b;
        int          wbc, misc, fsc;
        logic [5:0]  order[$];

        i_rst = 1'b1; i_memop_valid = 1'b0; i_memop_store = 1'b0; i_memop_sign_ext = 1'b0;
        i_memop_size = 2'd0; i_memop_addr = '0; i_memop_wdata = '0; i_memop_waddr = '0;
        i_memop_wtag = '0; i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0;
        i_mem_resp_data = '0; i_mem_resp_fault = 1'b0; i_wb_ready = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
        #3;
        check1("reset_memop_ready", o_memop_ready, 1'b1);
        check1("reset_idle", o_idle, 1'b1);
        check1("reset_req_valid", o_mem_req_valid, 1'b0);
        check1("reset_wb_valid", o_wb_valid, 1'b0);
        tick();

        // Signed word load from the upper half of the dword, plus request latency
        i_mem_req_ready = 1'b1;
        i_memop_valid = 1'b1; i_memop_store = 1'b0; i_memop_sign_ext = 1'b1; i_memop_size = 2'd2;
        i_memop_addr = 64'h1004; i_memop_wdata = '0; i_memop_waddr = 6'd5; i_memop_wtag = 3'd3;
        #3 check1("lw_accept", o_memop_ready, 1'b1);
        tick(); i_memop_valid = 1'b0;
        #3 check1("lw_lat_n1", o_mem_req_valid, 1'b0);
        tick();
        #3;
        check1("lw_lat_n2", o_mem_req_valid, 1'b1);
        check64("lw_req_addr", o_mem_req_addr, 64'h1004);
        check64("lw_req_wstrb", 64'(o_mem_req_wstrb), 64'h0);
        tick();
        i_mem_resp_valid = 1'b1; i_mem_resp_data = 64'h8000_0000_0000_0000; i_mem_resp_fault = 1'b0;
        #3 check1("lw_resp_ready", o_mem_resp_ready, 1'b1);
        tick(); i_mem_resp_valid = 1'b0;
        #3;
        check1("lw_wb_valid", o_wb_valid, 1'b1);
        check64("lw_wb_wdata", o_wb_wdata, 64'hFFFF_FFFF_8000_0000);
        check64("lw_wb_waddr", 64'(o_wb_waddr), 64'd5);
        tick(); i_wb_ready = 1'b1;
        #3 check1("lw_wb_held", o_wb_valid, 1'b1);
        tick(); i_wb_ready = 1'b0;
        #3 check1("lw_done_idle", o_idle, 1'b1);
        tick();

        // Byte store: replicated lanes, single strobe, no writeback
        push_op(1'b1, 1'b0, 2'd0, 64'h1003, 64'hAB, 6'd7, 3'd1);
        observe(1'b0, saw_req, rwd, rst_b, wbc, misc, maddr, fsc, fin);
        check1("sb_req_seen", saw_req, 1'b1);
        check64("sb_req_wdata", rwd, 64'hABAB_ABAB_ABAB_ABAB);
        check64("sb_req_wstrb", 64'(rst_b), 64'h08);
        check64("sb_wb_cycles", 64'(wbc), 64'd0);
        check1("sb_finished", fin, 1'b1);

        // Misaligned half load
        push_op(1'b0, 1'b0, 2'd1, 64'h1001, 64'h0, 6'd4, 3'd2);
        observe(1'b0, saw_req, rwd, rst_b, wbc, misc, maddr, fsc, fin);
        check64("lh_mis_cycles", 64'(misc), 64'd1);
        check64("lh_mis_addr", maddr, 64'h1001);
        check1("lh_no_req", saw_req, 1'b0);
        check1("lh_finished", fin, 1'b1);

        // Faulting store
        push_op(1'b1, 1'b0, 2'd3, 64'h2000, 64'h55, 6'd3, 3'd0);
        observe(1'b1, saw_req, rwd, rst_b, wbc, misc, maddr, fsc, fin);
        check64("sd_fault_cycles", 64'(fsc), 64'd1);
        check64("sd_wb_cycles", 64'(wbc), 64'd0);
        check1("sd_finished", fin, 1'b1);

        // Queue fills while the cache stalls; completion order preserved
        i_mem_req_ready = 1'b0; i_wb_ready = 1'b1;
        push_op(1'b0, 1'b0, 2'd3, 64'h3000, 64'h0, 6'd1, 3'd1);
        push_op(1'b0, 1'b0, 2'd3, 64'h3008, 64'h0, 6'd2, 3'd2);
        push_op(1'b0, 1'b0, 2'd3, 64'h3010, 64'h0, 6'd3, 3'd3);
        #3 check1("q3_full_not_ready", o_memop_ready, 1'b0);
        tick();
        i_mem_req_ready = 1'b1; i_mem_resp_valid = 1'b1; i_mem_resp_data = 64'hCAFE_0000_1111_2222;
        fin = 1'b0;
        for (int n = 0; n < 80 && !fin; n++) begin
            #3;
            if (o_wb_valid) order.push_back(o_wb_waddr);
            fin = o_idle;
            tick();
        end
        i_mem_resp_valid = 1'b0;
        check1("q3_finished", fin, 1'b1);
        check64("q3_wb_count", 64'(order.size()), 64'd3);
        for (int i = 0; i < order.size(); i++) check64("q3_wb_order", 64'(order[i]), 64'(i + 1));

        // Reset while waiting on a response with another op queued
        i_mem_req_ready = 1'b1; i_mem_resp_valid = 1'b0;
        push_op(1'b0, 1'b0, 2'd3, 64'h4000, 64'h0, 6'd9, 3'd1);
        push_op(1'b0, 1'b0, 2'd3, 64'h4008, 64'h0, 6'd10, 3'd2);
        tick();
        #3 check1("rw_in_waitresp", o_mem_resp_ready, 1'b1);
        tick();
        i_rst = 1'b1; i_mem_resp_valid = 1'b1; i_wb_ready = 1'b1;
        #3 check1("rw_reset_idle", o_idle, 1'b1);
        tick(); i_rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            #3;
            check1("rw_post_idle", o_idle, 1'b1);
            check1("rw_post_no_wb", o_wb_valid, 1'b0);
            check1("rw_post_no_req", o_mem_req_valid, 1'b0);
            tick();
        end
        i_mem_resp_valid = 1'b0;

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            i_rst            = ($urandom_range(0, 499) == 0);
            i_memop_valid    = ($urandom_range(0, 2) != 0);
            i_memop_store    = $urandom_range(0, 1) == 1;
            i_memop_sign_ext = $urandom_range(0, 1) == 1;
            i_memop_size     = 2'($urandom_range(0, 3));
            i_memop_addr     = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                i_memop_addr = i_memop_addr & ~((64'd1 << i_memop_size) - 64'd1);
            i_memop_wdata    = {$urandom, $urandom};
            i_memop_waddr    = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            i_memop_wtag     = 3'($urandom_range(0, 7));
            i_mem_req_ready  = ($urandom_range(0, 3) != 0);
            i_mem_resp_valid = ($urandom_range(0, 2) != 0);
            i_mem_resp_data  = {$urandom, $urandom};
            i_mem_resp_fault = ($urandom_range(0, 9) == 0);
            i_wb_ready       = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Drain: everything accepted must complete
        i_rst = 1'b0; i_memop_valid = 1'b0; i_mem_req_ready = 1'b1;
        i_mem_resp_valid = 1'b1; i_mem_resp_fault = 1'b0; i_wb_ready = 1'b1;
        fin = 1'b0;
        for (int n = 0; n < 200 && !fin; n++) begin
            tick();
            #3 fin = o_idle && (model.size() == 0);
        end
        check1("drain_complete", fin, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
